// File: rtl/mul_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM encodings and default operand width.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned MUL_WIDTH = 8;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on {ACC, Q, Q-1}: conditional add/sub of M, then arithmetic shift right.
module booth_step
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH+2:0] i_acq,
  input  logic [WIDTH:0]     i_m,
  output logic [2*WIDTH+2:0] o_acq
);

  localparam int unsigned OpW = WIDTH + 1;

  logic [OpW-1:0] w_acc;
  logic [OpW-1:0] w_q;
  logic           w_q1;
  logic [OpW:0]   w_sum;

  assign w_acc = i_acq[2*WIDTH+2 -: OpW];
  assign w_q   = i_acq[OpW:1];
  assign w_q1  = i_acq[0];

  // One guard bit keeps the add/sub exact before the shift drops it again.
  always_comb begin
    w_sum = {w_acc[OpW-1], w_acc};
    case ({w_q[0], w_q1})
      2'b01:   w_sum = {w_acc[OpW-1], w_acc} + {i_m[OpW-1], i_m};
      2'b10:   w_sum = {w_acc[OpW-1], w_acc} - {i_m[OpW-1], i_m};
      default: w_sum = {w_acc[OpW-1], w_acc};
    endcase
  end

  assign o_acq = {w_sum[OpW:1], w_sum[0], w_q[OpW-1:1], w_q[0]};

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle radix-2 Booth multiplier, signed or unsigned, with valid/ready on both sides.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     DATA1,
  input  logic [WIDTH-1:0]     DATA2,
  input  logic                 SIGNED_MODE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   PRODUCT,
  output logic [WIDTH-1:0]     RESULT,
  output logic                 OVERFLOW,
  output logic                 ZERO
);

  localparam int unsigned ITER = WIDTH + 1;
  localparam int unsigned OpW  = WIDTH + 1;
  localparam int unsigned RegW = 2 * OpW + 1;
  localparam int unsigned CntW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StCalc = ST_CALC,
    StDone = ST_DONE
  } state_e;

  state_e             r_state;
  logic [RegW-1:0]    r_acq;
  logic [OpW-1:0]     r_m;
  logic [CntW-1:0]    r_cnt;
  logic               r_signed;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_product;
  logic               r_ovf;
  logic               r_zero;

  logic [RegW-1:0]    w_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [OpW-1:0]     w_q_ext;
  logic [OpW-1:0]     w_m_ext;
  logic               w_ovf;
  logic               w_zero;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acq(r_acq),
    .i_m  (r_m),
    .o_acq(w_next)
  );

  // {ACC, Q} holds the exact product; only its low 2*WIDTH bits are reported.
  assign w_prod  = w_next[2*WIDTH:1];
  assign w_m_ext = SIGNED_MODE ? {DATA1[WIDTH-1], DATA1} : {1'b0, DATA1};
  assign w_q_ext = SIGNED_MODE ? {DATA2[WIDTH-1], DATA2} : {1'b0, DATA2};

  always_comb begin
    w_zero = (w_prod == '0);
    if (r_signed) begin
      w_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    end else begin
      w_ovf = |w_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= StIdle;
      r_acq       <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (IN_VALID) begin
            r_m        <= w_m_ext;
            r_acq      <= {{OpW{1'b0}}, w_q_ext, 1'b0};
            r_signed   <= SIGNED_MODE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StCalc;
          end
        end
        StCalc: begin
          r_acq <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(ITER - 1)) begin
            r_product   <= w_prod;
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign PRODUCT   = r_product;
  assign RESULT    = r_product[WIDTH-1:0];
  assign OVERFLOW  = r_ovf;
  assign ZERO      = r_zero;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed operands push expected results, a monitor checks them.
module tb_booth_mul_seq;

  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   DATA1;
  logic [W-1:0]   DATA2;
  logic           SIGNED_MODE;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [2*W-1:0] PRODUCT;
  logic [W-1:0]   RESULT;
  logic           OVERFLOW;
  logic           ZERO;

  typedef struct {
    logic [15:0] p;
    logic        o;
    logic        z;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  booth_mul_seq #(
    .WIDTH(W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .DATA1      (DATA1),
    .DATA2      (DATA2),
    .SIGNED_MODE(SIGNED_MODE),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .PRODUCT    (PRODUCT),
    .RESULT     (RESULT),
    .OVERFLOW   (OVERFLOW),
    .ZERO       (ZERO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at t=%0t", nm, $time);
  endtask

  // Monitor: one pop per OUT_VALID assertion, however long it is held.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      seen = 1'b0;
    end else if (OUT_VALID && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        e = sb.pop_front();
        chk("product",  32'(PRODUCT),  32'(e.p));
        chk("result",   32'(RESULT),   32'(e.p[7:0]));
        chk("overflow", 32'(OVERFLOW), 32'(e.o));
        chk("zero",     32'(ZERO),     32'(e.z));
        chk("latency",  32'(cyc - e.c), 32'd9);
      end
    end else if (!OUT_VALID) begin
      seen = 1'b0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue(input logic [7:0] d1, input logic [7:0] d2, input logic sm,
                       input logic [15:0] ep, input logic eo, input logic ez, input bit push);
    int n = 0;
    exp_t e;
    while (!IN_READY && n < 50) begin
      tick(1);
      n++;
    end
    if (!IN_READY) timeout("in_ready_wait");
    DATA1       = d1;
    DATA2       = d2;
    SIGNED_MODE = sm;
    IN_VALID    = 1'b1;
    tick(1);
    IN_VALID    = 1'b0;
    // Scramble operands after accept; the result must not depend on them.
    DATA1       = 8'($urandom);
    DATA2       = 8'($urandom);
    SIGNED_MODE = ~sm;
    if (push) begin
      e.p = ep; e.o = eo; e.z = ez; e.c = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || OUT_VALID) && n < 60) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  initial begin
    int n;
    RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    DATA1 = '0; DATA2 = '0; SIGNED_MODE = 1'b0;
    tick(2);
    chk("rst_in_ready",  32'(IN_READY),  32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_product",   32'(PRODUCT),   32'd0);
    chk("rst_ovf_zero",  32'({OVERFLOW, ZERO}), 32'd0);
    RESET = 1'b1;
    tick(1);

    issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 1'b0, 1'b1); drain();
    issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b1); drain();
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 1'b0, 1'b1); drain();
    issue(8'hC8, 8'hC8, 1'b0, 16'h9C40, 1'b1, 1'b0, 1'b1); drain();
    issue(8'h0C, 8'h0A, 1'b0, 16'h0078, 1'b0, 1'b0, 1'b1); drain();
    issue(8'h00, 8'h7F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1); drain();
    issue(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1); drain();
    issue(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1, 1'b0, 1'b1); drain();
    issue(8'h80, 8'h02, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1); drain();
    issue(8'h05, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1); drain();

    // Back-pressure with a competing request that must be ignored.
    OUT_READY = 1'b0;
    issue(8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (!OUT_VALID && n < 30) begin
      tick(1);
      n++;
    end
    if (!OUT_VALID) timeout("bp_out_valid");
    DATA1 = 8'h01; DATA2 = 8'h01; SIGNED_MODE = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_in_ready",  32'(IN_READY),  32'd0);
      chk("bp_product",   32'(PRODUCT),   32'h3F01);
      chk("bp_overflow",  32'(OVERFLOW),  32'd1);
    end
    OUT_READY = 1'b1;
    IN_VALID  = 1'b0;
    tick(1);
    chk("bp_release_valid", 32'(OUT_VALID), 32'd0);
    chk("bp_release_ready", 32'(IN_READY),  32'd1);
    tick(12);

    // Reset during CALC abandons the operation.
    issue(8'h05, 8'h06, 1'b0, 16'h001E, 1'b0, 1'b0, 1'b0);
    tick(3);
    RESET = 1'b0;
    tick(1);
    chk("abort_out_valid", 32'(OUT_VALID), 32'd0);
    chk("abort_in_ready",  32'(IN_READY),  32'd1);
    chk("abort_product",   32'(PRODUCT),   32'd0);
    chk("abort_result",    32'(RESULT),    32'd0);
    chk("abort_flags",     32'({OVERFLOW, ZERO}), 32'd0);
    RESET = 1'b1;
    tick(15);
    issue(8'h03, 8'h03, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b1); drain();
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised, multi-cycle radix-2 Booth multiplier that replaces the single-shot combinational multiply path of the ALU. It computes a full 2*WIDTH-bit product with one add/sub plus shift per clock, in signed or unsigned mode. It reports overflow when the truncated WIDTH-bit result is wrong. It connects to the ALU through a valid/ready handshake on both input and output, so the core can stall on multiply instead of widening the cycle time.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
ITER, WIDTH+1 (derived localparam, not overridable), Booth iterations per operation

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  synchronous, active-low reset
IN_VALID  input  1  operands and mode valid this cycle
IN_READY  output  1  block can accept operands
DATA1  input  WIDTH  multiplicand
DATA2  input  WIDTH  multiplier
SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned
OUT_VALID  output  1  PRODUCT/RESULT/flags valid
OUT_READY  input  1  consumer accepts result
PRODUCT  output  2*WIDTH  full product
RESULT  output  WIDTH  PRODUCT[WIDTH-1:0]
OVERFLOW  output  1  RESULT does not represent the true product
ZERO  output  1  PRODUCT == 0

Behaviour:
- Reset (RESET==0 at a rising edge): state IDLE, IN_READY=1, OUT_VALID=0, PRODUCT=0, RESULT=0, OVERFLOW=0, ZERO=0, iteration counter=0. Reset overrides every other input.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID at an edge, latch the operands into a (WIDTH+1)-bit internal form: sign-extended if SIGNED_MODE=1, zero-extended if 0.
  - Latch the mode, clear the accumulator and Q-1, set counter=0, then go to CALC.
- CALC:
  - IN_READY=0.
  - Each edge performs one Booth step on {ACC, Q, Q-1}:
    - 01: ACC+=M
    - 10: ACC-=M
    - 00/11: no operation
  - Each step is followed by an arithmetic right shift of the full register.
  - Counter increments each step. After step ITER, register PRODUCT, flags and OUT_VALID=1, then go to DONE.
- Latency: the operand accept edge is edge 0 and OUT_VALID rises after edge ITER (9 cycles for WIDTH=8).
- DONE:
  - OUT_VALID=1, IN_READY=0; PRODUCT, RESULT and flags hold stable.
  - On OUT_READY at an edge: OUT_VALID=0, go to IDLE.
  - Throughput: at least one bubble cycle between results (no accept while in DONE).
- IN_VALID is ignored outside IDLE. Operand inputs may change freely after the accept edge without affecting the result.
- SIGNED_MODE is sampled only at accept.
- Width rule: the internal accumulator is WIDTH+1 bits so that -2^(WIDTH-1) * -2^(WIDTH-1) and the unsigned maximums are exact. PRODUCT is the low 2*WIDTH bits of the exact result.
- OVERFLOW:
  - Signed mode: PRODUCT[2*WIDTH-1:WIDTH-1] is not all-equal.
  - Unsigned mode: PRODUCT[2*WIDTH-1:WIDTH] != 0.
- ZERO is computed from PRODUCT, not from RESULT.
- Reset mid-operation (CALC or DONE) abandons the operation. No OUT_VALID pulse for that operation ever appears.
- A multiplier of 0 still takes the full ITER cycles (no early termination).

Decomposition:
- Shared package mul_pkg:
  - state encoding localparams ST_IDLE=2'b00, ST_CALC=2'b01, ST_DONE=2'b10
  - default width constant MUL_WIDTH=8
- One sub-module, booth_step: combinational, parametrised by WIDTH. It takes {ACC,Q,Q-1} and M and returns the next add/sub+ASR register. It is instantiated once and used every CALC cycle.
- Counter, FSM, handshake and flag logic stay in booth_mul_seq.

Test Plan:
- Signed, WIDTH=8, DATA1=8'hFD (-3), DATA2=8'h05 -> after exactly 9 cycles: OUT_VALID=1, PRODUCT=16'hFFF1, RESULT=8'hF1, OVERFLOW=0, ZERO=0.
- Signed, -128*-128 (8'h80,8'h80) -> PRODUCT=16'h4000, OVERFLOW=1. Unsigned 255*255 -> PRODUCT=16'hFE01, OVERFLOW=1.
- Unsigned 200*200 (8'hC8,8'hC8) -> PRODUCT=16'h9C40, RESULT=8'h40, OVERFLOW=1. Unsigned 12*10 -> 16'h0078, OVERFLOW=0.
- Back-pressure: hold OUT_READY=0 for 5 cycles after OUT_VALID, with a new IN_VALID applied meanwhile -> outputs stable, IN_READY=0, new operands ignored. Raise OUT_READY -> OUT_VALID drops next edge and IN_READY=1.
- Zero operand: 8'h00 * 8'h7F signed -> PRODUCT=0, ZERO=1, still 9-cycle latency.
- Assert RESET=0 at cycle 4 of CALC -> next edge IDLE, all outputs 0. A subsequent 3*3 yields 16'h0009 with no stale result.
